serial_link_ddr_rx: RTL

- Receive end of the FPGA-to-FPGA DDR serial link.
- The peer drives a 4-lane data bus plus a forwarded clock. This block oversamples both in the local system clock, captures one nibble on every forwarded-clock edge (rising and falling), and assembles LSB-first 32-bit words.
- Completed words are buffered in a first-word-fall-through FIFO and offered on a valid/ready port to the MCU-side consumer. FIFO state also appears on pad-level flags.

---
 rtl/serial_link_ddr_rx_if.sv | 21 ++
 rtl/serial_link_ddr_rx.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_link_ddr_rx_if.sv
// Consumer-side valid/ready word port of the DDR serial link receiver.
// The receiver uses the master modport; the MCU-side consumer uses slave.
interface serial_link_ddr_rx_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] rdata_o;
    logic                  rvalid_o;
    logic                  rready_i;

    modport master (
        output rdata_o,
        output rvalid_o,
        input  rready_i
    );

    modport slave (
        input  rdata_o,
        input  rvalid_o,
        output rready_i
    );
endinterface

// File: rtl/serial_link_ddr_rx.sv
// Receive end of the FPGA-to-FPGA DDR serial link: oversamples lanes and forwarded
// clock, assembles LSB-first words on both forwarded-clock edges and queues them in a FWFT FIFO.
module serial_link_ddr_rx #(
    parameter int LANES        = 4,
    parameter int DATA_WIDTH   = 32,
    parameter int FIFO_DEPTH   = 8,
    parameter int IDLE_TIMEOUT = 64
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic                             en_i,
    input  logic                             clear_i,
    input  logic [LANES-1:0]                 ddr_i,
    input  logic                             ddr_rcv_clk_i,
    serial_link_ddr_rx_if.master             rd,
    output logic                             fifo_empty_o,
    output logic                             fifo_full_o,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  count_o,
    output logic                             overflow_o,
    output logic                             frame_err_o
);
    localparam int NIBBLES = DATA_WIDTH / LANES;
    localparam int NIB_W   = $clog2(NIBBLES);
    localparam int TMR_W   = $clog2(IDLE_TIMEOUT);
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);

    localparam logic [NIB_W-1:0] LAST_NIB = NIB_W'(NIBBLES - 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(IDLE_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

    typedef enum logic {
        ST_IDLE,
        ST_RECV
    } state_t;

    logic                  r_clkSync1;
    logic                  r_clkSync2;
    logic                  r_clkPrev;
    logic [LANES-1:0]      r_dataSync1;
    logic [LANES-1:0]      r_dataSync2;

    state_t                r_state;
    logic [NIB_W-1:0]      r_nibCnt;
    logic [TMR_W-1:0]      r_timer;
    logic [DATA_WIDTH-1:0] r_shift;
    logic                  r_pushValid;
    logic [DATA_WIDTH-1:0] r_pushData;
    logic                  r_frameErr;

    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      r_wrPtr;
    logic [PTR_W-1:0]      r_rdPtr;
    logic [CNT_W-1:0]      r_count;
    logic                  r_overflow;

    logic                  w_edge;
    state_t                w_stateNext;
    logic [NIB_W-1:0]      w_nibCntNext;
    logic [TMR_W-1:0]      w_timerNext;
    logic [DATA_WIDTH-1:0] w_shiftNext;
    logic                  w_wordDone;
    logic                  w_frameErr;
    logic                  w_empty;
    logic                  w_full;
    logic                  w_pop;
    logic                  w_pushOk;

    // Data and clock share identical synchronizer depth so captured nibbles stay aligned.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_clkSync1  <= 1'b0;
            r_clkSync2  <= 1'b0;
            r_clkPrev   <= 1'b0;
            r_dataSync1 <= '0;
            r_dataSync2 <= '0;
        end else begin
            r_clkSync1  <= ddr_rcv_clk_i;
            r_clkSync2  <= r_clkSync1;
            r_clkPrev   <= r_clkSync2;
            r_dataSync1 <= ddr_i;
            r_dataSync2 <= r_dataSync1;
        end
    end

    assign w_edge = r_clkSync2 ^ r_clkPrev;

    always_comb begin
        w_stateNext  = r_state;
        w_nibCntNext = r_nibCnt;
        w_timerNext  = r_timer;
        w_shiftNext  = r_shift;
        w_wordDone   = 1'b0;
        w_frameErr   = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                w_nibCntNext = '0;
                w_timerNext  = '0;
                if (en_i && w_edge) begin
                    w_stateNext            = ST_RECV;
                    w_shiftNext[LANES-1:0] = r_dataSync2;
                    w_nibCntNext           = NIB_W'(1);
                end
            end
            ST_RECV: begin
                if (!en_i) begin
                    w_stateNext  = ST_IDLE;
                    w_nibCntNext = '0;
                    w_timerNext  = '0;
                end else if (w_edge) begin
                    w_shiftNext[LANES*int'(r_nibCnt) +: LANES] = r_dataSync2;
                    w_timerNext = '0;
                    if (r_nibCnt == LAST_NIB) begin
                        w_wordDone   = 1'b1;
                        w_nibCntNext = '0;
                    end else begin
                        w_nibCntNext = r_nibCnt + 1'b1;
                    end
                end else if (r_timer == TMR_LAST) begin
                    // A timeout with nibbles pending means the peer abandoned a word mid-frame.
                    w_stateNext  = ST_IDLE;
                    w_nibCntNext = '0;
                    w_timerNext  = '0;
                    w_frameErr   = (r_nibCnt != '0);
                end else begin
                    w_timerNext = r_timer + 1'b1;
                end
            end
            default: begin
                w_stateNext = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni || clear_i) begin
            r_state     <= ST_IDLE;
            r_nibCnt    <= '0;
            r_timer     <= '0;
            r_shift     <= '0;
            r_pushValid <= 1'b0;
            r_pushData  <= '0;
            r_frameErr  <= 1'b0;
        end else begin
            r_state     <= w_stateNext;
            r_nibCnt    <= w_nibCntNext;
            r_timer     <= w_timerNext;
            r_shift     <= w_shiftNext;
            r_pushValid <= w_wordDone;
            r_frameErr  <= w_frameErr;
            if (w_wordDone) begin
                r_pushData <= w_shiftNext;
            end
        end
    end

    assign w_empty  = (r_count == '0);
    assign w_full   = (r_count == CNT_FULL);
    assign w_pop    = !w_empty && rd.rready_i;
    // A simultaneous pop frees the head slot, so a push into a full FIFO is still accepted.
    assign w_pushOk = r_pushValid && (!w_full || w_pop);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_wrPtr    <= '0;
            r_rdPtr    <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (clear_i) begin
            r_wrPtr    <= '0;
            r_rdPtr    <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_pushOk) begin
                r_mem[r_wrPtr] <= r_pushData;
                r_wrPtr        <= r_wrPtr + 1'b1;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            if (w_pushOk && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_pushOk && w_pop) begin
                r_count <= r_count - 1'b1;
            end
            if (r_pushValid && w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign rd.rdata_o   = r_mem[r_rdPtr];
    assign rd.rvalid_o  = !w_empty;
    assign fifo_empty_o = w_empty;
    assign fifo_full_o  = w_full;
    assign count_o      = r_count;
    assign overflow_o   = r_overflow;
    assign frame_err_o  = r_frameErr;
endmodule
